// File: rtl/alu_seq.sv
// alu_seq: slice-serial ALU. Computes a WIDTH-bit ADD/SUB/AND/OR by running
// one SLICE-bit datapath for N = WIDTH/SLICE cycles, LSB slice first.
// Results and the R/Co/V/Z flags are registered.
//
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   When defined, the carry-in sampled at accept is taken from a stored carry
//   if chain=1. The stored carry holds the Co of the last completed operation
//   and is updated at the DONE handshake. This allows multi-precision adds.
//   When undefined, the carry-in is always Ci and the chain input is ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready request handshake (in_ready high only in IDLE)
//   A, B, S, Ci, chain  operands, op (00 ADD, 01 SUB, 10 AND, 11 OR), carry-in,
//                       chain select; all sampled on the accept edge only
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   R, Co, V, Z         result, carry out, signed overflow, zero flag
//
// state | meaning
// IDLE  | waiting for in_valid; operands captured on accept
// RUN   | processing slice k each cycle, k = 0 .. N-1
// DONE  | result and flags held until out_ready
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S,
  input  logic             Ci,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             Co,
  output logic             V,
  output logic             Z
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [1:0]       s_q;
  logic             c_q;
  logic [KW-1:0]    k_q;
  logic             co_q, v_q, z_q;
  logic             carry_in;

  logic [31:0]      shamt;
  logic [SLICE-1:0] a_sl, b_sl, b_eff, res_sl;
  logic [SLICE:0]   sum_sl;
  logic             c_out_sl, c_msb_sl, arith, last;
  logic [WIDTH-1:0] r_new;

`ifdef ALU_SEQ_CHAIN_EN
  logic carry_st_q;

  assign carry_in = chain ? carry_st_q : Ci;

  // Co is already 0 for AND/OR, so a logic completion clears the stored carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_st_q <= 1'b0;
    end else if (state == DONE && out_ready) begin
      carry_st_q <= co_q;
    end
  end
`else
  logic unused_chain;

  assign carry_in     = Ci;
  assign unused_chain = chain;
`endif

  // Slice datapath: select slice k of the captured operands.
  always_comb begin
    shamt    = 32'(k_q) * 32'(SLICE);
    arith    = ~s_q[1];
    last     = (k_q == K_LAST);
    a_sl     = SLICE'(a_q >> shamt);
    b_sl     = SLICE'(b_q >> shamt);
    b_eff    = s_q[0] ? ~b_sl : b_sl;
    sum_sl   = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, c_q};
    c_out_sl = sum_sl[SLICE];
    // Carry into the slice MSB, recovered from its sum bit; on the final
    // slice this is the carry into the word MSB used for V.
    c_msb_sl = a_sl[SLICE-1] ^ b_eff[SLICE-1] ^ sum_sl[SLICE-1];
    if (arith) begin
      res_sl = sum_sl[SLICE-1:0];
    end else if (s_q[0]) begin
      res_sl = a_sl | b_sl;
    end else begin
      res_sl = a_sl & b_sl;
    end
    r_new = (r_q & ~(WIDTH'({SLICE{1'b1}}) << shamt)) | (WIDTH'(res_sl) << shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      c_q  <= 1'b0;
      r_q  <= '0;
      k_q  <= '0;
      co_q <= 1'b0;
      v_q  <= 1'b0;
      z_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= A;
            b_q <= B;
            s_q <= S;
            c_q <= carry_in;
            r_q <= '0;
            k_q <= '0;
          end
        end
        RUN: begin
          r_q <= r_new;
          c_q <= arith & c_out_sl;
          if (last) begin
            k_q  <= '0;
            co_q <= arith & c_out_sl;
            v_q  <= arith & (c_msb_sl ^ c_out_sl);
            z_q  <= ~|r_new;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign R  = r_q;
  assign Co = co_q;
  assign V  = v_q;
  assign Z  = z_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int WIDTH = 16;
  localparam int N     = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

`ifdef ALU_SEQ_CHAIN_EN
  localparam logic [15:0] CHAIN_R = 16'h0001;
  localparam logic        CHAIN_Z = 1'b0;
`else
  localparam logic [15:0] CHAIN_R = 16'h0000;
  localparam logic        CHAIN_Z = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A, B;
  logic [1:0]       S;
  logic             Ci, chain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic             Co, V, Z;

  typedef struct {
    logic [15:0] r;
    logic        co;
    logic        v;
    logic        z;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  alu_seq #(.WIDTH(WIDTH), .SLICE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .S         (S),
    .Ci        (Ci),
    .chain     (chain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .Co        (Co),
    .V         (V),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard at every result handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: R=%h Co=%b V=%b Z=%b, required no result", R, Co, V, Z);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({R, Co, V, Z} !== {e.r, e.co, e.v, e.z}) begin
          n_fail++;
          $display("FAIL %s: R=%h Co=%b V=%b Z=%b, required R=%h Co=%b V=%b Z=%b",
                   e.name, R, Co, V, Z, e.r, e.co, e.v, e.z);
        end
      end
    end
  end

  // Issue one operation, push its expected result at accept, and check the
  // out_valid latency. Returns just after the edge that enters DONE.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] s, input logic ci, input logic ch,
                        input logic [15:0] er, input logic eco, input logic ev, input logic ez);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_accept_timeout: in_ready=%b, required 1", nm, in_ready);
      return;
    end
    A = a; B = b; S = s; Ci = ci; chain = ch; in_valid = 1'b1;
    e.r = er; e.co = eco; e.v = ev; e.z = ez; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs during RUN; they must have no effect.
    A = 16'(~a); B = 16'(b ^ 16'h5A5A); S = ~s; Ci = ~ci; chain = ~ch;
    repeat (N - 1) @(posedge clk);
    #1 check({nm, "_lat_early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check({nm, "_lat"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; S = '0; Ci = 1'b0; chain = 1'b0;
    #3;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_R",         32'(R),         32'd0);
    check("rst_flags",     32'({Co, V, Z}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf",   16'h7FFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub_eq",    16'h1234, 16'h1234, OP_SUB, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_neg",   16'h0000, 16'h0001, OP_SUB, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, OP_SUB, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("add_ci",    16'hFFFF, 16'h0000, OP_ADD, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("and",       16'hF0F0, 16'h0FF0, OP_AND, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    run_op("or_zero",   16'h0000, 16'h0000, OP_OR,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("or",        16'hA000, 16'h0505, OP_OR,  1'b0, 1'b0, 16'hA505, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold DONE for 5 cycles, pulse in_valid meanwhile.
    @(posedge clk);
    #1 out_ready = 1'b0;
    run_op("bp_add", 16'h1234, 16'h1111, OP_ADD, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_R",        32'(R),          32'h2345);
      check("bp_flags",    32'({Co, V, Z}), 32'd0);
      check("bp_in_ready", 32'(in_ready),   32'd0);
      check("bp_valid",    32'(out_valid),  32'd1);
      in_valid = (i == 2);
      A = 16'hFFFF; B = 16'hFFFF; S = OP_ADD;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("bp_no_stray_accept", 32'(in_ready), 32'd1);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    A = 16'h00FF; B = 16'h00FF; S = OP_ADD; Ci = 1'b0; chain = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(in_ready),     32'd1);
    check("midrst_out_valid", 32'(out_valid),    32'd0);
    check("midrst_R",         32'(R),            32'd0);
    check("midrst_flags",     32'({Co, V, Z}),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 16'h0001, 16'h0001, OP_ADD, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Multi-precision chaining.
    run_op("chain_src", 16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("chain_use", 16'h0000, 16'h0000, OP_ADD, 1'b0, 1'b1, CHAIN_R, 1'b0, 1'b0, CHAIN_Z);
    run_op("chain_src2", 16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("chain_clr",  16'h0000, 16'h0000, OP_OR,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("chain_after_clr", 16'h0000, 16'h0000, OP_ADD, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised slice-serial ALU: computes a WIDTH-bit add/sub/AND/OR by iterating one SLICE-bit datapath over WIDTH/SLICE clock cycles, with registered R/Co/V/Z flags. It is the sequential successor to the chained 2-bit-slice ALU: it trades latency for area and adds valid/ready handshakes so it can sit between pipeline stages in the datapath.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 2, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- A  in  WIDTH  operand A, sampled on accept.
- B  in  WIDTH  operand B, sampled on accept.
- S  in  2  op: 00 ADD, 01 SUB, 10 AND, 11 OR; sampled on accept.
- Ci  in  1  carry in, sampled on accept.
- chain  in  1  use stored previous Co as carry-in (see Configuration).
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- R  out  WIDTH  result.
- Co  out  1  carry out.
- V  out  1  signed overflow.
- Z  out  1  result == 0.

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. If in_valid, then at the clock edge:
  - latch A, B, S, and the carry-in;
  - clear R and the slice counter k;
  - go to RUN.
- RUN: each cycle processes slice k, bits [k·SLICE +: SLICE]:
  - ADD: A + B + c.
  - SUB: A + ~B + c. Ci=1 gives a true A−B.
  - The slice carry-out is registered as c for slice k+1.
  - AND/OR: bitwise; c is forced to 0.
  - The R slice is written and k increments.
  - After slice N−1 (N=WIDTH/SLICE), go to DONE.
- Flags are updated on the final slice:
  - Co = final carry (0 for AND/OR).
  - V = carry into MSB XOR carry out of MSB (0 for AND/OR).
  - Z = NOR of all WIDTH result bits. Z is computed from the complete R, not per slice.
- DONE: out_valid=1. R/Co/V/Z are held stable.
  - On out_ready, go to IDLE at the clock edge.
  - The stored chain carry is set to Co.
- Inputs A/B/S/Ci are ignored outside the accept edge. Changing them during RUN has no effect.
- in_valid during RUN or DONE is not accepted. in_ready=0 there.

## Timing
- Reset (rst_n=0, immediately, any state): state=IDLE; in_ready=1, out_valid=0, R=0, Co=0, V=0, Z=0; k=0; chain carry=0.
- Reset mid-RUN or mid-DONE aborts the operation. No result is produced.
- Latency: the accept edge is t0. RUN occupies cycles t0+1 … t0+N. out_valid rises after edge t0+N.
  - Example: WIDTH=16, SLICE=2 gives N=8.
- Throughput: one operation per N+2 cycles minimum: accept, N RUN, one DONE cycle with out_ready=1, then back to IDLE.
- out_ready held low: stay in DONE indefinitely with outputs unchanged.
- SLICE=WIDTH: N=1. This is a single-cycle RUN; the same state sequence applies.
- out_valid and in_ready are decoded from state only. There is no combinational path from in_valid or out_ready to them.

## Configuration
- Macro: ALU_SEQ_CHAIN_EN.
- Defined: at accept, carry-in = chain ? stored_carry : Ci. This enables multi-precision chaining.
  - stored_carry = Co of the last completed ADD/SUB, captured at the DONE handshake.
  - An AND/OR completion clears stored_carry.
- Undefined: carry-in = Ci always; the chain port is ignored; the stored-carry register is not built.

## Test plan
- ADD, A=0x7FFF, B=0x0001, Ci=0 → after 8 RUN cycles: out_valid=1, R=0x8000, Co=0, V=1, Z=0.
- SUB, A=0x1234, B=0x1234, Ci=1 → R=0x0000, Co=1, V=0, Z=1. Also SUB 0x0000−0x0001 with Ci=1 → R=0xFFFF, Co=0, V=0.
- AND 0xF0F0 & 0x0FF0 → R=0x00F0, Co=0, V=0. OR 0x0000 | 0x0000 → R=0, Z=1.
- Backpressure: out_ready low for 5 cycles after DONE → R/flags stable, in_ready=0, a pulsed in_valid is not accepted. Raising out_ready → IDLE the next cycle, in_ready=1.
- Reset: assert rst_n=0 during RUN cycle 4 → outputs 0 and in_ready=1 immediately. After release, a new ADD 0x0001+0x0001 → R=0x0002.
- With ALU_SEQ_CHAIN_EN: ADD 0xFFFF+0x0001 (Co=1), then ADD 0x0000+0x0000 with chain=1 → R=0x0001. Without the macro, the same sequence gives R=0x0000.
